// File: rtl/cpu_control_pkg.sv
// Shared definitions for the cpu_control sequencer: step encoding, opcodes and
// instruction field positions.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   localparam int IR_W      = 9;
   localparam int OP_MSB    = 8;
   localparam int OP_LSB    = 6;
   localparam int RX_MSB    = 5;
   localparam int RX_LSB    = 3;
   localparam int RY_MSB    = 2;
   localparam int RY_LSB    = 0;
   localparam int REG_IDX_W = 3;
   localparam int NUM_REGS  = 8;

   function automatic logic is_alu_op(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

   // Opcodes 100..111 have no defined meaning and execute as a one-step NOP.
   function automatic logic is_reserved(input logic [2:0] op);
      return op[2];
   endfunction

endpackage

// File: rtl/cpu_control_if.sv
// Control/bus handshake between the sequencer (master) and the datapath (slave).
// The illegal flag exists only when CPU_CTRL_ILLEGAL_FLAG_EN is defined.
interface cpu_control_if #(
   parameter int DW   = 16,
   parameter int NREG = 8
);
   logic            run;
   logic [DW-1:0]   din;
   logic            irin;
   logic [NREG-1:0] rin;
   logic [NREG-1:0] rout;
   logic            ain;
   logic            gin;
   logic            gout;
   logic            dinout;
   logic            sub;
   logic            done;
`ifdef CPU_CTRL_ILLEGAL_FLAG_EN
   logic            illegal;

   modport master (
      input  run, din,
      output irin, rin, rout, ain, gin, gout, dinout, sub, done, illegal
   );
   modport slave (
      output run, din,
      input  irin, rin, rout, ain, gin, gout, dinout, sub, done, illegal
   );
`else
   modport master (
      input  run, din,
      output irin, rin, rout, ain, gin, gout, dinout, sub, done
   );
   modport slave (
      output run, din,
      input  irin, rin, rout, ain, gin, gout, dinout, sub, done
   );
`endif
endinterface

// File: rtl/cpu_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable, used for register load/drive selection.
module dec3to8
   import cpu_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] i_idx,
   input  logic                 i_en,
   output logic [NUM_REGS-1:0]  o_onehot
);

   always_comb begin
      o_onehot = '0;
      if (i_en) o_onehot[i_idx] = 1'b1;
   end

endmodule

// File: rtl/cpu_control.sv
// Instruction sequencer: fetches a 9-bit instruction and steps T0..T3 issuing
// one-hot control words. Optional sticky illegal flag: CPU_CTRL_ILLEGAL_FLAG_EN.
module cpu_control
   import cpu_ctrl_pkg::*;
#(
   parameter int NREG = 8,
   parameter int DW   = 16
)(
   input  logic clock,
   input  logic reset,
   cpu_control_if.master bus
);

   state_t              r_state;
   state_t              w_next;
   logic [IR_W-1:0]     r_ir;
   logic [2:0]          w_op;
   logic [2:0]          w_rx;
   logic [2:0]          w_ry;
   logic                w_rin_en;
   logic                w_rout_en;
   logic [2:0]          w_rin_idx;
   logic [2:0]          w_rout_idx;
   logic [NREG-1:0]     w_rin;
   logic [NREG-1:0]     w_rout;
   logic                w_irin;
   logic                w_ain;
   logic                w_gin;
   logic                w_gout;
   logic                w_dinout;
   logic                w_sub;
   logic                w_done;
   logic                w_unused_din_hi;

   // Upper din bits carry immediates for the datapath; the decoder never looks at them.
   assign w_unused_din_hi = ^bus.din[DW-1:IR_W];

   assign w_op = r_ir[OP_MSB:OP_LSB];
   assign w_rx = r_ir[RX_MSB:RX_LSB];
   assign w_ry = r_ir[RY_MSB:RY_LSB];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= T0;
         r_ir    <= '0;
      end else begin
         r_state <= w_next;
         if (w_irin) r_ir <= bus.din[IR_W-1:0];
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         T0:      if (bus.run) w_next = T1;
         T1:      w_next = is_alu_op(w_op) ? T2 : T0;
         T2:      w_next = T3;
         T3:      w_next = T0;
         default: w_next = T0;
      endcase
   end

   always_comb begin
      w_irin     = 1'b0;
      w_rin_en   = 1'b0;
      w_rin_idx  = w_rx;
      w_rout_en  = 1'b0;
      w_rout_idx = w_rx;
      w_ain      = 1'b0;
      w_gin      = 1'b0;
      w_gout     = 1'b0;
      w_dinout   = 1'b0;
      w_sub      = 1'b0;
      w_done     = 1'b0;
      case (r_state)
         T0: w_irin = bus.run;
         T1: begin
            case (w_op)
               OP_MV: begin
                  w_rout_en  = 1'b1;
                  w_rout_idx = w_ry;
                  w_rin_en   = 1'b1;
                  w_done     = 1'b1;
               end
               OP_MVI: begin
                  w_dinout = 1'b1;
                  w_rin_en = 1'b1;
                  w_done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  w_rout_en = 1'b1;
                  w_ain     = 1'b1;
               end
               default: w_done = 1'b1;
            endcase
         end
         T2: begin
            if (is_alu_op(w_op)) begin
               w_rout_en  = 1'b1;
               w_rout_idx = w_ry;
               w_gin      = 1'b1;
               w_sub      = w_op[0];
            end
         end
         T3: begin
            w_gout   = 1'b1;
            w_rin_en = 1'b1;
            w_done   = 1'b1;
         end
         default: ;
      endcase
   end

   dec3to8 u_dec_rin (
      .i_idx    (w_rin_idx),
      .i_en     (w_rin_en),
      .o_onehot (w_rin)
   );

   dec3to8 u_dec_rout (
      .i_idx    (w_rout_idx),
      .i_en     (w_rout_en),
      .o_onehot (w_rout)
   );

   assign bus.irin   = w_irin;
   assign bus.rin    = w_rin;
   assign bus.rout   = w_rout;
   assign bus.ain    = w_ain;
   assign bus.gin    = w_gin;
   assign bus.gout   = w_gout;
   assign bus.dinout = w_dinout;
   assign bus.sub    = w_sub;
   assign bus.done   = w_done;

`ifdef CPU_CTRL_ILLEGAL_FLAG_EN
   logic r_illegal;

   // Raised on the edge that leaves T1 of a reserved opcode; only reset clears it.
   always_ff @(posedge clock) begin
      if (reset)                                      r_illegal <= 1'b0;
      else if (r_state == T1 && is_reserved(w_op))    r_illegal <= 1'b1;
   end

   assign bus.illegal = r_illegal;
`else
   // Reserved opcodes execute as silent NOPs with no flag.
`endif

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: per-instruction control-word schedule model
// compared every cycle, plus directed literal checks and a random instruction stream.
module tb_cpu_control;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   cpu_control_if #(.DW(16), .NREG(8)) bus();

   cpu_control #(.NREG(8), .DW(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [22:0] w;
      bit          rsv;
   } step_t;

   step_t q[$];
   bit    m_illegal = 1'b0;
   bit    chk_en    = 1'b0;
   int    n_checks  = 0;
   int    n_errors  = 0;
   int    done_cnt  = 0;

   // Word layout: irin | rin[7:0] | rout[7:0] | ain | gin | gout | dinout | sub | done
   function automatic logic [22:0] cw(input logic irin, input logic [7:0] rin,
                                      input logic [7:0] rout, input logic ain,
                                      input logic gin, input logic gout,
                                      input logic dinout, input logic sub,
                                      input logic done);
      return {irin, rin, rout, ain, gin, gout, dinout, sub, done};
   endfunction

   function automatic logic [22:0] dut_word();
      return cw(bus.irin, bus.rin, bus.rout, bus.ain, bus.gin, bus.gout,
                bus.dinout, bus.sub, bus.done);
   endfunction

   task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Queue the control words of the post-fetch steps of one instruction.
   task automatic expand(input logic [8:0] ir);
      logic [2:0] op;
      logic [7:0] mx;
      logic [7:0] my;
      op = ir[8:6];
      mx = 8'b1 << ir[5:3];
      my = 8'b1 << ir[2:0];
      case (op)
         3'd0: q.push_back('{cw(0, mx, my, 0, 0, 0, 0, 0, 1), 1'b0});
         3'd1: q.push_back('{cw(0, mx, 8'h00, 0, 0, 0, 1, 0, 1), 1'b0});
         3'd2, 3'd3: begin
            q.push_back('{cw(0, 8'h00, mx, 1, 0, 0, 0, 0, 0), 1'b0});
            q.push_back('{cw(0, 8'h00, my, 0, 1, 0, 0, op[0], 0), 1'b0});
            q.push_back('{cw(0, mx, 8'h00, 0, 0, 1, 0, 0, 1), 1'b0});
         end
         default: q.push_back('{cw(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1), 1'b1});
      endcase
   endtask

   // Model advance on each rising edge.
   initial begin
      forever begin
         @(posedge clock);
         if (reset) begin
            q.delete();
            m_illegal = 1'b0;
         end else if (q.size() != 0) begin
            if (q[0].rsv) m_illegal = 1'b1;
            void'(q.pop_front());
         end else if (bus.run) begin
            expand(bus.din[8:0]);
         end
      end
   end

   // Per-cycle comparison against the model, plus structural invariants.
   initial begin
      logic [22:0] exp_w;
      forever begin
         @(negedge clock);
         if (chk_en) begin
            exp_w = (q.size() == 0) ? cw(bus.run, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0) : q[0].w;
            check("ctrl_word", dut_word(), exp_w);
`ifdef CPU_CTRL_ILLEGAL_FLAG_EN
            check("illegal_model", 23'(bus.illegal), 23'(m_illegal));
`endif
            check("bus_exclusive",
                  23'(($countones(bus.rout) + int'(bus.gout) + int'(bus.dinout)) <= 1), 23'(1));
            check("rin_onehot", 23'($countones(bus.rin) <= 1), 23'(1));
            if (bus.done) done_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic lit(input string name, input logic [22:0] exp);
      #2;
      check(name, dut_word(), exp);
   endtask

   initial begin
      int issued;
      int cyc;
      reset   = 1'b1;
      bus.run = 1'b0;
      bus.din = 16'h0000;
      repeat (2) @(posedge clock);
      #1;
      chk_en = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         lit("idle_after_reset", 23'h0);
         tick();
      end

      // Reset wins over run: fetch attempt is discarded, no done follows.
      bus.run = 1'b1;
      bus.din = 16'h0000;
      reset   = 1'b1;
      lit("fetch_under_reset", cw(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      tick();
      reset   = 1'b0;
      bus.run = 1'b0;
      lit("no_done_after_reset", 23'h0);
      tick();
      lit("still_idle", 23'h0);
      tick();

      // mvi r1,#0x1234
      bus.run = 1'b1;
      bus.din = 16'h0048;
      lit("mvi_fetch", cw(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      tick();
      bus.run = 1'b0;
      bus.din = 16'h1234;
      lit("mvi_t1", cw(0, 8'h02, 8'h00, 0, 0, 0, 1, 0, 1));
      tick();
      bus.din = 16'h0000;
      lit("mvi_idle", 23'h0);
      tick();

      // mv r3,r2
      bus.run = 1'b1;
      bus.din = 16'h001A;
      #2;
      tick();
      bus.run = 1'b0;
      lit("mv_t1", cw(0, 8'h08, 8'h04, 0, 0, 0, 0, 0, 1));
      tick();

      // add r1,r2 then sub r1,r2 back-to-back
      bus.run = 1'b1;
      bus.din = 16'h008A;
      lit("add_fetch", cw(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      tick();
      lit("add_t1", cw(0, 8'h00, 8'h02, 1, 0, 0, 0, 0, 0));
      tick();
      lit("add_t2", cw(0, 8'h00, 8'h04, 0, 1, 0, 0, 0, 0));
      tick();
      bus.din = 16'h00CA;
      lit("add_t3", cw(0, 8'h02, 8'h00, 0, 0, 1, 0, 0, 1));
      tick();
      lit("sub_fetch", cw(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0));
      tick();
      lit("sub_t1", cw(0, 8'h00, 8'h02, 1, 0, 0, 0, 0, 0));
      tick();
      bus.run = 1'b0;
      lit("sub_t2", cw(0, 8'h00, 8'h04, 0, 1, 0, 0, 1, 0));
      tick();
      lit("sub_t3", cw(0, 8'h02, 8'h00, 0, 0, 1, 0, 0, 1));
      tick();

      // Reserved opcode
      bus.run = 1'b1;
      bus.din = 16'h0100;
      #2;
      tick();
      bus.run = 1'b0;
      lit("rsv_t1", cw(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
`ifdef CPU_CTRL_ILLEGAL_FLAG_EN
      check("illegal_in_t1", 23'(bus.illegal), 23'(0));
`endif
      tick();
`ifdef CPU_CTRL_ILLEGAL_FLAG_EN
      #2;
      check("illegal_set", 23'(bus.illegal), 23'(1));
`endif
      repeat (3) tick();
`ifdef CPU_CTRL_ILLEGAL_FLAG_EN
      #2;
      check("illegal_sticky", 23'(bus.illegal), 23'(1));
`endif
      reset = 1'b1;
      tick();
      reset = 1'b0;
`ifdef CPU_CTRL_ILLEGAL_FLAG_EN
      #2;
      check("illegal_cleared", 23'(bus.illegal), 23'(0));
`endif
      tick();

      // Reset in T2 of add r0,r1
      bus.run = 1'b1;
      bus.din = 16'h0081;
      #2;
      tick();
      bus.run = 1'b0;
      tick();
      reset = 1'b1;
      lit("mid_t2", cw(0, 8'h00, 8'h02, 0, 1, 0, 0, 0, 0));
      tick();
      reset = 1'b0;
      lit("mid_reset_drop", 23'h0);
      tick();

      // Random instruction stream
      done_cnt = 0;
      issued   = 0;
      cyc      = 0;
      while (issued < 1000 && cyc < 20000) begin
         if (q.size() == 0) begin
            bus.run = ($urandom_range(3) != 0);
            bus.din = 16'($urandom);
            if (bus.run) issued++;
         end else begin
            bus.run = 1'($urandom_range(1));
            bus.din = 16'($urandom);
         end
         tick();
         cyc++;
      end
      check("rand_budget", 23'(issued), 23'(1000));
      bus.run = 1'b0;
      repeat (6) tick();
      check("done_count", 23'(done_cnt), 23'(issued));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
Control sequencer that drives the ALU's control interface (ain, gin, sub) and the shared 16-bit bus. It also drives register-file load/drive enables and the bus source select.
- Fetches a 9-bit instruction from din, then steps T0..T3 issuing one-hot control words.
- Sits beside the ALU and register file as the initiator; it never touches data itself.

Parameters:
- NREG, 8, number of general registers; fixed at 8 to match the 3-bit register fields.
- DW, 16, bus/din width; only din[8:0] is decoded.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; returns FSM to T0 and clears IR.
- run  in  1  start request; sampled in T0.
- din  in  DW  instruction word in T0; immediate data in T1 of mvi.
- irin  out  1  IR load strobe; shown for observability, IR is internal.
- rin  out  NREG  one-hot register load enable.
- rout  out  NREG  one-hot register bus-drive enable.
- ain  out  1  ALU A-register load.
- gin  out  1  ALU G-register load.
- gout  out  1  G drives bus.
- dinout  out  1  din drives bus.
- sub  out  1  ALU mode: 1 = subtract, 0 = add.
- done  out  1  final step of instruction.

Behaviour:
- Instruction format (IR[8:0] = din[8:0] captured in T0): op = IR[8:6], rx = IR[5:3], ry = IR[2:0]. Opcodes:
  - 000 mv rx,ry
  - 001 mvi rx,#D
  - 010 add rx,ry
  - 011 sub rx,ry
  - 100-111 reserved
- States T0, T1, T2, T3. Reset gives state = T0, IR = 0.
- Outputs are combinational from state, IR and run. In T0 with run=0, every output is 0.
- T0:
  - run=1: irin=1, IR <= din[8:0], next T1.
  - run=0: stay in T0, IR unchanged.
- mv, T1: rout[ry]=1, rin[rx]=1, done=1. Next T0.
- mvi, T1: dinout=1, rin[rx]=1, done=1. Next T0. The immediate must be on din during this cycle.
- add/sub, T1: rout[rx]=1, ain=1. Next T2.
- add/sub, T2: rout[ry]=1, gin=1, sub=op[0]. Next T3.
- add/sub, T3: gout=1, rin[rx]=1, done=1. Next T0.
- Reserved op, T1: done=1 only, no enables (NOP). Next T0.
- sub is 0 in every cycle except T2 of a sub instruction.
- Latency, run-to-done: mv/mvi/NOP take 2 cycles, add/sub take 4.
- Back-to-back instructions: if run=1 in the T0 after done, the next fetch starts with no idle cycle.
- Bus exclusivity: at most one of {any rout bit, gout, dinout} is 1 in any cycle. At most one rin bit is 1.
- rx == ry is legal:
  - mv r3,r3 gives rout[3]=rin[3]=1 in the same cycle.
  - add r3,r3 doubles r3.
- run is ignored outside T0.
- Reset mid-instruction: the next state is T0 and IR is 0. Outputs therefore drop to 0 the cycle after the reset edge, with no partial done.
- Reset wins over run in the same cycle.

Optional Feature:
- Macro: CPU_CTRL_ILLEGAL_FLAG_EN.
- When defined:
  - Extra output `illegal` (1 bit), sticky.
  - Set at the clock edge leaving T1 of a reserved opcode.
  - Cleared only by reset.
- When undefined: the port is absent and reserved opcodes are silent NOPs. Timing is identical in both builds.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state encoding T0..T3 (2-bit).
  - opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011.
  - field-position constants.
- One sub-module, dec3to8: 3-bit index plus enable in, 8-bit one-hot out. Two instances are used for rin and rout selection.

Test Plan:
- Reset hold, then release with run=0 for 5 cycles -> all outputs 0, state T0; run=1 with din=0x000 then reset on the T1 edge -> no done observed.
- mvi: din=0x048 (op 001, rx=1) with run=1, then din=0x1234 -> T0 irin=1; T1 dinout=1, rin=0x02, done=1; idle in T0 afterwards.
- mv: din=0x01A (rx=3, ry=2) -> T1 rout=0x04, rin=0x08, done=1.
- add then sub back-to-back: din=0x08A (add r1,r2) then din=0x0CA (sub r1,r2), run held high. Check:
  - add: T1 rout=0x02 ain=1; T2 rout=0x04 gin=1 sub=0; T3 gout=1 rin=0x02 done=1.
  - sub: fetch begins the next cycle, and T2 shows sub=1.
- Reserved op din=0x100 -> T1 done=1 with all enables 0. With the macro, `illegal` rises after T1 and stays 1 until reset.
- Random instruction stream (1000 ops) -> every cycle satisfies the bus-exclusivity and rin one-hot checks, and done count equals issued count.
